// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store initiator between the execute stage and a byte-strobed data
// memory. Takes one request at a time, turns it into one or two word-aligned
// memory beats with byte strobes, rebuilds and extends load data, and returns a
// single-cycle response.
//
// Build option:
//   LSU_MISALIGNED_SPLIT_EN  defined   -> misaligned accesses are allowed;
//                                         word-crossing ones take two beats.
//                            undefined -> misaligned half/word accesses fault
//                                         without touching memory.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only while idle)
//   i_req_we              1 = store, 0 = load
//   i_req_size            0 byte, 1 half, 2 word, 3 reserved (faults)
//   i_req_unsigned        zero-extend load result
//   i_req_addr            byte address
//   i_req_wdata           right-aligned store data
//   o_mem_we/addr/wdata/wstrb  registered memory beat signals
//   i_mem_rdata           combinational read data for o_mem_addr
//   o_rsp_valid           one-cycle response pulse (loads and stores)
//   o_rsp_rdata           extended load result, 0 for stores/faults
//   o_rsp_fault           access fault, memory untouched
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;

    // Request fields held for the duration of the access
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic            cross_q, cross_d;
    logic [XLEN-1:0] whi_q, whi_d;     // beat-1 lane-positioned write data
    logic [2:0]      shi_q, shi_d;     // beat-1 strobes
    logic [XLEN-1:0] rlo_q, rlo_d;     // read data captured at end of beat 0

    // Registered outputs
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_fault_q, rsp_fault_d;

    // Request decode
    logic [1:0]        req_off;
    logic [3:0]        req_mask;
    logic [6:0]        req_strb;
    logic [2*XLEN-1:0] req_wd;
    logic              req_cross;
    logic              req_fault;

    // Shift the two-word read buffer down to the addressed byte, then
    // truncate and extend according to the access size.
    function automatic logic [XLEN-1:0] load_result(
        input logic [2*XLEN-1:0] rbuf,
        input logic [1:0]        size,
        input logic [1:0]        off,
        input logic              uns
    );
        logic [XLEN-1:0] sh;
        sh = XLEN'(rbuf >> (BYTE_WIDTH * off));
        case (size)
            2'd0:    return {{(XLEN-BYTE_WIDTH){sh[BYTE_WIDTH-1] & ~uns}},
                             sh[BYTE_WIDTH-1:0]};
            2'd1:    return {{(XLEN-2*BYTE_WIDTH){sh[2*BYTE_WIDTH-1] & ~uns}},
                             sh[2*BYTE_WIDTH-1:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        req_off = i_req_addr[1:0];
        case (i_req_size)
            2'd0:    req_mask = 4'h1;
            2'd1:    req_mask = 4'h3;
            2'd2:    req_mask = 4'hF;
            default: req_mask = 4'h0;
        endcase
        // Strobes and data spread over two words; the upper part is beat 1.
        req_strb = 7'(req_mask) << req_off;
        req_wd   = {{XLEN{1'b0}}, i_req_wdata} << (BYTE_WIDTH * req_off);
`ifdef LSU_MISALIGNED_SPLIT_EN
        req_cross = |req_strb[6:4];
        req_fault = (i_req_size == 2'd3);
`else
        // Misaligned accesses fault, so no accepted access can cross a word.
        req_cross = 1'b0;
        req_fault = (i_req_size == 2'd3)
                 || ((i_req_size == 2'd1) && i_req_addr[0])
                 || ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'd0));
`endif
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cross_d     = cross_q;
        whi_d       = whi_q;
        shi_d       = shi_q;
        rlo_d       = rlo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    off_d   = req_off;
                    cross_d = req_cross;
                    whi_d   = req_wd[2*XLEN-1:XLEN];
                    shi_d   = req_strb[6:4];
                    if (req_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_we_d    = i_req_we;
                        mem_addr_d  = {i_req_addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = req_wd[XLEN-1:0];
                        mem_wstrb_d = req_strb[3:0];
                    end
                end
            end
            BEAT0: begin
                rlo_d = i_mem_rdata;
                if (cross_q) begin
                    state_d     = BEAT1;
                    mem_we_d    = we_q;
                    mem_addr_d  = mem_addr_q + XLEN'(4);
                    mem_wdata_d = whi_q;
                    mem_wstrb_d = {1'b0, shi_q};
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!we_q)
                        rsp_rdata_d = load_result({{XLEN{1'b0}}, i_mem_rdata},
                                                  size_q, off_q, uns_q);
                end
            end
            BEAT1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (!we_q)
                    rsp_rdata_d = load_result({i_mem_rdata, rlo_q},
                                              size_q, off_q, uns_q);
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            cross_q     <= 1'b0;
            whi_q       <= '0;
            shi_q       <= '0;
            rlo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cross_q     <= cross_d;
            whi_q       <= whi_d;
            shi_q       <= shi_d;
            rlo_q       <= rlo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_fault = rsp_fault_q;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the execute stage and the byte-strobed data memory.
- Accepts one load/store request at a time and converts it into word-aligned memory beats with byte strobes.
- Memory protocol: combinational read, write committed on clock edge.
- Reassembles read data, applies sign or zero extension, and returns a single-cycle response.
- Splits word-crossing accesses into two beats when the split feature is compiled in.

Parameters:
- XLEN, 32: address width and data width. Only 32 is supported.
- BYTE_WIDTH, 8: bits per strobe lane.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready; high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- i_req_unsigned  in  1  zero-extend load result (LBU/LHU).
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, right-aligned.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  XLEN  word-aligned memory address.
- o_mem_wdata  out  XLEN  lane-positioned write data.
- o_mem_wstrb  out  4  byte strobes.
- i_mem_rdata  in  XLEN  combinational read data for o_mem_addr.
- o_rsp_valid  out  1  one-cycle response pulse, issued for loads and stores.
- o_rsp_rdata  out  XLEN  extended load result; 0 for stores and faults.
- o_rsp_fault  out  1  access fault; no memory write has occurred.

Behaviour:
- Reset values:
  - State IDLE.
  - o_req_ready = 1.
  - o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_rsp_valid, o_rsp_rdata, o_rsp_fault all 0.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Handshake: a request is accepted on a rising edge with i_req_valid && o_req_ready. All request fields are registered at acceptance.
- Offset and lane rules:
  - off = addr[1:0]; mask = 1, 3 or F for byte, half or word.
  - Full strobe = mask << off (7 bits). Bits [3:0] form beat-0 strobes; bits [6:4] form beat-1 strobes.
  - wdata is shifted left by 8*off across 64 bits. Low word goes to beat 0, high word to beat 1.
- Beat addresses:
  - Beat-0 address = {addr[XLEN-1:2], 2'b00}.
  - Beat-1 address = beat-0 address + 4, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0x00000000).
- Crossing condition: full strobe bits [6:4] nonzero.
- Fault conditions, decided at acceptance:
  - size = 3.
  - Misalignment per the Optional Feature section.
- Transitions:
  - IDLE -> BEAT0 on accept; on a fault, IDLE -> RESP with fault = 1.
  - BEAT0 -> BEAT1 if crossing, else -> RESP.
  - BEAT1 -> RESP.
  - RESP -> IDLE.
- Memory signals are registered outputs, valid only during BEAT0 and BEAT1.
  - o_mem_we = store flag during beats; 0 otherwise.
  - o_mem_wstrb = 0 outside beats.
  - Load beats also drive strobes; memory ignores them when we = 0.
- Read capture: i_mem_rdata is sampled at the end of each beat into a 64-bit buffer (beat 0 low, beat 1 high).
- Load result:
  - Result = (buffer >> 8*off), truncated to the access size.
  - Sign-extended from bit 7 or 15 unless i_req_unsigned; word loads are unextended.
- Response: o_rsp_valid = 1 for exactly the RESP cycle; o_rsp_rdata and o_rsp_fault are valid with it. No response backpressure.
- Latency from the acceptance edge: fault 1 cycle, single beat 2 cycles, split 3 cycles. Throughput is one request per (latency + 1) cycles.
- i_req_* changes while not ready are ignored.
- Reset mid-operation:
  - Returns to IDLE immediately and drops o_mem_we asynchronously.
  - Beat-0 write already committed stays committed; the pending beat-1 write is abandoned.
  - No response is issued.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - Only size = 3 faults.
  - Any non-crossing access takes one beat (e.g. half at off 1).
  - Crossing accesses take BEAT0 + BEAT1.
- Undefined:
  - Half with addr[0] = 1 or word with addr[1:0] != 0 faults, with no memory beat.
  - BEAT1 is unreachable and may be omitted.

Test Plan:
- Load byte: mem[0x100] = 0x80FF7F01. LB 0x103 -> BEAT0 addr 0x100, rsp at +2 cycles with rdata 0xFFFFFF80. LBU 0x103 -> 0x00000080. LB 0x101 -> 0x0000007F.
- Store half: SH wdata 0x1234BEEF at 0x102 -> single beat: addr 0x100, wstrb 4'b1100, wdata 0xBEEF0000, we 1. Rsp fault 0, rdata 0.
- Split store (macro on): SW 0x11223344 at 0x103.
  - Beat 0: addr 0x100, strb 1000, wdata 0x44000000.
  - Beat 1: addr 0x104, strb 0111, wdata 0x00112233.
  - Rsp at +3.
  - Macro off: rsp at +1 with fault 1; o_mem_we never asserted.
- Split load (macro on): mem[0x100] = 0xDDCCBBAA, mem[0x104] = 0x44332211.
  - LW 0x102 -> 0x2211DDCC.
  - LH 0x103 -> 0x000011DD.
  - LH 0xFFFFFFFF with mem[0x0] = 0x7F -> beat-1 address wraps to 0x00000000.
- Faults and reset:
  - size = 3 at 0x100 -> fault 1, no beat.
  - Assert i_rst during BEAT1 of a split SW -> o_mem_we = 0 immediately, o_req_ready = 1, no o_rsp_valid. Bytes from beat 0 remain written.
- Back-to-back: i_req_valid held high with two aligned LW requests -> o_req_ready low for 2 cycles; second request accepted on the IDLE edge; two responses 3 cycles apart.
